// File: rtl/uart_regbank_pkg.sv
// rtl/uart_regbank_pkg.sv - shared widths, reset values, RO mask and read-pipe entry type for the UART register bank
package uart_regbank_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 4;
  localparam int RB_NUM_REGS   = 8;

  localparam logic [DATA_WIDTH-1:0] RB_RESET_VALS [RB_NUM_REGS] = '{
    8'h00, 8'h00, 8'h81, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Prescale register (2) is fixed after reset
  localparam logic [RB_NUM_REGS-1:0] RB_RO_MASK = 8'b0000_0100;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rb_rd_req_t;

  // Registers beyond the table reset to zero; the loop keeps the lookup in bounds
  function automatic logic [DATA_WIDTH-1:0] rb_reset_val(input int idx);
    rb_reset_val = '0;
    for (int i = 0; i < RB_NUM_REGS; i++) begin
      if (i == idx) rb_reset_val = RB_RESET_VALS[i];
    end
  endfunction

endpackage

// File: rtl/uart_regbank_rd_pipe.sv
// rtl/uart_regbank_rd_pipe.sv - RD_LATENCY-deep read response shift register with zero-gated data
module uart_regbank_rd_pipe
  import uart_regbank_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  rb_rd_req_t req,
  output rb_rd_req_t rsp
);

  rb_rd_req_t req_gated;
  rb_rd_req_t stage [RD_LATENCY];

  // Empty slots carry all-zero so o_RdData is 0 whenever valid is low
  always_comb begin
    req_gated = req;
    if (!req.valid) req_gated = '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < RD_LATENCY; k++) stage[k] <= '0;
    end else begin
      stage[0] <= req_gated;
      for (int k = 1; k < RD_LATENCY; k++) stage[k] <= stage[k-1];
    end
  end

  assign rsp = stage[RD_LATENCY-1];

endmodule

// File: rtl/uart_regbank.sv
// rtl/uart_regbank.sv - UART config register bank; UART_REGBANK_SHADOW_EN drives o_Regs from a commit-updated shadow
module uart_regbank #(
  parameter int                   DATA_WIDTH    = uart_regbank_pkg::DATA_WIDTH,
  parameter int                   ADDRESS_WIDTH = uart_regbank_pkg::ADDRESS_WIDTH,
  parameter int                   NUM_REGS      = uart_regbank_pkg::RB_NUM_REGS,
  parameter int                   RD_LATENCY    = 1,
  parameter logic [NUM_REGS-1:0]  RO_MASK       = NUM_REGS'(uart_regbank_pkg::RB_RO_MASK)
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic                           i_WrEn,
  input  logic                           i_RdEn,
  input  logic [ADDRESS_WIDTH-1:0]       i_Address,
  input  logic [DATA_WIDTH-1:0]          i_WrData,
  input  logic                           i_Commit,
  output logic [DATA_WIDTH-1:0]          o_RdData,
  output logic                           o_RdData_Valid,
  output logic                           o_Err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_Regs,
  output logic                           o_Cfg_Updated
);
  import uart_regbank_pkg::*;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("uart_regbank: RD_LATENCY must be 1 or 2");
  end
  if (NUM_REGS > (1 << ADDRESS_WIDTH)) begin : g_bad_depth
    $error("uart_regbank: NUM_REGS exceeds the address space");
  end
  if (DATA_WIDTH != uart_regbank_pkg::DATA_WIDTH) begin : g_bad_width
    $error("uart_regbank: DATA_WIDTH must match the package read-pipe entry");
  end

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   addr_sel;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  addr_ro;
  logic                  in_range;
  logic                  wr_legal;
  logic                  wr_err;
  logic                  rd_err;
  logic                  cfg_evt;
  logic                  wr_err_q;
  logic                  cfg_upd_q;
  rb_rd_req_t            rd_req;
  rb_rd_req_t            rd_rsp;

  // One-hot decode; an address past NUM_REGS selects nothing and reads as 0
  always_comb begin
    addr_sel = '0;
    rd_mux   = '0;
    addr_ro  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_Address == ADDRESS_WIDTH'(i)) begin
        addr_sel[i] = 1'b1;
        rd_mux      = regs[i];
        addr_ro     = RO_MASK[i];
      end
    end
  end

  assign in_range = |addr_sel;
  assign wr_legal = i_WrEn & in_range & ~addr_ro;
  assign wr_err   = i_WrEn & ~(in_range & ~addr_ro);
  assign rd_err   = i_RdEn & ~in_range;

  // A write error in a read cycle rides with that read, giving one pulse per event cycle
  assign rd_req.valid = i_RdEn;
  assign rd_req.err   = i_RdEn & (rd_err | wr_err);
  assign rd_req.data  = rd_mux;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= rb_reset_val(i);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_legal && addr_sel[i]) regs[i] <= i_WrData;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_err_q  <= 1'b0;
      cfg_upd_q <= 1'b0;
    end else begin
      wr_err_q  <= wr_err & ~i_RdEn;
      cfg_upd_q <= cfg_evt;
    end
  end

  uart_regbank_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .CLK  (CLK),
    .RSTn (RSTn),
    .req  (rd_req),
    .rsp  (rd_rsp)
  );

`ifdef UART_REGBANK_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];

  // Forward a same-cycle legal write so the commit captures the new value
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= rb_reset_val(i);
    end else if (i_Commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= (wr_legal && addr_sel[i]) ? i_WrData : regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_oregs
    assign o_Regs[g*DATA_WIDTH +: DATA_WIDTH] = shadow[g];
  end

  assign cfg_evt = i_Commit;
`else
  logic unused_commit;
  assign unused_commit = i_Commit;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_oregs
    assign o_Regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign cfg_evt = wr_legal;
`endif

  assign o_RdData       = rd_rsp.data;
  assign o_RdData_Valid = rd_rsp.valid;
  assign o_Err          = rd_rsp.err | wr_err_q;
  assign o_Cfg_Updated  = cfg_upd_q;

endmodule
